nexys4_io_hub: RTL and testbench

- Parametrised successor to the single-PicoBlaze Nexys4 port interface.
- Decodes a generic bank of N input ports and M read-back output ports. Adds a multi-source interrupt controller with pending, mask and end-of-interrupt (EOI) registers.
- Sits between one KCPSM6 core and the board/Rojobot I/O, replacing hand-coded per-port case decoders.

---
 rtl/nexys4_io_hub.sv | 168 ++++++++++++++++
 tb/tb_nexys4_io_hub.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/nexys4_io_hub.sv
// nexys4_io_hub: PicoBlaze (KCPSM6) I/O decoder with a generic input/output
// port bank and a small edge-triggered interrupt controller
// (pending / mask / cause registers plus an EOI re-arm handshake).
// Optional build macro NEXYS4_IO_HUB_SYNC_EN adds 2-flop synchronisers on
// in_ports and irq_req. Without it, inputs are assumed to be already
// synchronous to sysclk.
module nexys4_io_hub #(
  parameter int         NUM_IN   = 8,
  parameter int         NUM_OUT  = 16,
  parameter int         NUM_IRQ  = 4,
  parameter logic [7:0] OUT_BASE = 8'h40,
  parameter logic [7:0] IRQ_BASE = 8'hF0
) (
  input  logic                   sysclk,
  input  logic                   sysreset,
  input  logic                   write_strobe,
  input  logic                   read_strobe,
  input  logic [7:0]             port_id,
  input  logic [7:0]             io_data_in,
  output logic [7:0]             io_data_out,
  output logic                   interrupt,
  input  logic                   interrupt_ack,
  input  logic [NUM_IN*8-1:0]    in_ports,
  output logic [NUM_OUT*8-1:0]   out_ports,
  input  logic [NUM_IRQ-1:0]     irq_req,
  output logic [NUM_IRQ-1:0]     irq_pending
);

  localparam int IN_HI  = NUM_IN - 1;
  localparam int OUT_LO = int'(OUT_BASE);
  localparam int OUT_HI = OUT_LO + NUM_OUT - 1;
  localparam int IRQ_LO = int'(IRQ_BASE);
  localparam int IRQ_HI = IRQ_LO + 2;

  localparam logic [7:0] ADDR_PEND  = IRQ_BASE;
  localparam logic [7:0] ADDR_MASK  = 8'(IRQ_LO + 1);
  localparam logic [7:0] ADDR_CAUSE = 8'(IRQ_LO + 2);

  // Reject illegal sizes and overlapping address windows at elaboration.
  if (NUM_IN < 1 || NUM_IN > 64) begin : g_bad_num_in
    $error("nexys4_io_hub: NUM_IN must be 1..64");
  end
  if (NUM_OUT < 1 || NUM_OUT > 64) begin : g_bad_num_out
    $error("nexys4_io_hub: NUM_OUT must be 1..64");
  end
  if (NUM_IRQ < 1 || NUM_IRQ > 8) begin : g_bad_num_irq
    $error("nexys4_io_hub: NUM_IRQ must be 1..8");
  end
  if (OUT_HI > 255 || IRQ_HI > 255) begin : g_bad_window_end
    $error("nexys4_io_hub: address window runs past 8'hFF");
  end
  if (OUT_LO <= IN_HI || IRQ_LO <= IN_HI ||
      (OUT_LO <= IRQ_HI && IRQ_LO <= OUT_HI)) begin : g_bad_overlap
    $error("nexys4_io_hub: address windows overlap");
  end

  logic [NUM_IN*8-1:0]  in_s;
  logic [NUM_IRQ-1:0]   irq_s;
  logic [NUM_OUT*8-1:0] out_q;
  logic [NUM_IRQ-1:0]   pending;
  logic [NUM_IRQ-1:0]   mask;
  logic [NUM_IRQ-1:0]   irq_hist;
  logic [NUM_IRQ-1:0]   irq_edge;
  logic [NUM_IRQ-1:0]   w1c_bits;
  logic                 armed;
  logic                 wr_pend;
  logic                 wr_mask;
  logic [7:0]           pend_b;
  logic [7:0]           mask_b;
  logic [7:0]           cause_b;
  logic [7:0]           rd_mux;

  // Reads are not qualified by read_strobe (PicoBlaze samples a free-running mux).
  logic unused_read_strobe;
  assign unused_read_strobe = read_strobe;

`ifdef NEXYS4_IO_HUB_SYNC_EN
  logic [NUM_IN*8-1:0] in_meta;
  logic [NUM_IRQ-1:0]  irq_meta;

  // Two-flop synchronisers for asynchronous board inputs.
  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      in_meta  <= '0;
      in_s     <= '0;
      irq_meta <= '0;
      irq_s    <= '0;
    end else begin
      in_meta  <= in_ports;
      in_s     <= in_meta;
      irq_meta <= irq_req;
      irq_s    <= irq_meta;
    end
  end
`else
  assign in_s  = in_ports;
  assign irq_s = irq_req;
`endif

  assign wr_pend  = write_strobe && (port_id == ADDR_PEND);
  assign wr_mask  = write_strobe && (port_id == ADDR_MASK);
  assign irq_edge = irq_s & ~irq_hist;
  assign w1c_bits = wr_pend ? io_data_in[NUM_IRQ-1:0] : '0;

  // Zero-extend the interrupt registers to a full byte for read-back.
  always_comb begin
    pend_b  = 8'h00;
    mask_b  = 8'h00;
    cause_b = 8'h00;
    pend_b[NUM_IRQ-1:0]  = pending;
    mask_b[NUM_IRQ-1:0]  = mask;
    cause_b[NUM_IRQ-1:0] = pending & mask;
  end

  // Address decode for the read mux; anything unmapped reads as zero.
  always_comb begin
    rd_mux = 8'h00;
    for (int k = 0; k < NUM_IN; k++) begin
      if (port_id == 8'(k)) rd_mux = in_s[8*k +: 8];
    end
    for (int k = 0; k < NUM_OUT; k++) begin
      if (port_id == 8'(OUT_LO + k)) rd_mux = out_q[8*k +: 8];
    end
    if (port_id == ADDR_PEND)  rd_mux = pend_b;
    if (port_id == ADDR_MASK)  rd_mux = mask_b;
    if (port_id == ADDR_CAUSE) rd_mux = cause_b;
  end

  // Registered read data and output-port writes.
  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      io_data_out <= 8'h00;
      out_q       <= '0;
    end else begin
      io_data_out <= rd_mux;
      for (int k = 0; k < NUM_OUT; k++) begin
        if (write_strobe && port_id == 8'(OUT_LO + k)) out_q[8*k +: 8] <= io_data_in;
      end
    end
  end

  // Interrupt controller: edge capture, W1C/EOI, mask and ack handshake.
  // A new edge beats a W1C of the same bit; ack beats a new request.
  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      irq_hist  <= '0;
      pending   <= '0;
      mask      <= '0;
      armed     <= 1'b1;
      interrupt <= 1'b0;
    end else begin
      irq_hist <= irq_s;
      pending  <= (pending & ~w1c_bits) | irq_edge;
      if (wr_mask) mask <= io_data_in[NUM_IRQ-1:0];
      if (interrupt_ack) begin
        armed     <= 1'b0;
        interrupt <= 1'b0;
      end else begin
        if (wr_pend) armed <= 1'b1;
        if (|(pending & mask) && armed) interrupt <= 1'b1;
      end
    end
  end

  assign out_ports   = out_q;
  assign irq_pending = pending;

endmodule

// File: tb/tb_nexys4_io_hub.sv
// Directed bench for nexys4_io_hub with default parameters.
module tb_nexys4_io_hub;

`ifdef NEXYS4_IO_HUB_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic         sysclk = 1'b0;
  logic         sysreset;
  logic         write_strobe;
  logic         read_strobe;
  logic [7:0]   port_id;
  logic [7:0]   io_data_in;
  logic [7:0]   io_data_out;
  logic         interrupt;
  logic         interrupt_ack;
  logic [63:0]  in_ports;
  logic [127:0] out_ports;
  logic [3:0]   irq_req;
  logic [3:0]   irq_pending;

  int n_tests = 0;
  int n_fail  = 0;
  logic [127:0] exp_out;

  nexys4_io_hub dut (
    .sysclk        (sysclk),
    .sysreset      (sysreset),
    .write_strobe  (write_strobe),
    .read_strobe   (read_strobe),
    .port_id       (port_id),
    .io_data_in    (io_data_in),
    .io_data_out   (io_data_out),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack),
    .in_ports      (in_ports),
    .out_ports     (out_ports),
    .irq_req       (irq_req),
    .irq_pending   (irq_pending)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic wait_sync();
    repeat (SYNC_LAT) tick();
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    port_id      = addr;
    io_data_in   = data;
    write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    port_id     = addr;
    read_strobe = 1'b1;
    tick();
    read_strobe = 1'b0;
    check(tag, 128'(io_data_out), 128'(exp));
  endtask

  task automatic ack();
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
  endtask

  initial begin
    sysreset      = 1'b0;
    write_strobe  = 1'b0;
    read_strobe   = 1'b0;
    port_id       = 8'h00;
    io_data_in    = 8'h00;
    interrupt_ack = 1'b0;
    irq_req       = 4'h0;
    in_ports      = '0;
    in_ports[7:0]   = 8'hA5;
    in_ports[15:8]  = 8'h5A;
    in_ports[63:56] = 8'hC3;
    #2;
    check("rst_data_out", 128'(io_data_out), 128'h0);
    check("rst_out_ports", out_ports, 128'h0);
    check("rst_interrupt", 128'(interrupt), 128'h0);
    check("rst_pending", 128'(irq_pending), 128'h0);

    @(posedge sysclk);
    #1 sysreset = 1'b1;

    // input window and its boundaries
    port_id = 8'h00;
    tick();
    wait_sync();
    check("rd_in0", 128'(io_data_out), 128'hA5);
    rd("rd_in1", 8'h01, 8'h5A);
    rd("rd_in_last", 8'h07, 8'hC3);
    rd("rd_in_past_end", 8'h08, 8'h00);
    rd("rd_unmapped_3f", 8'h3F, 8'h00);

    // output ports
    wr(8'h45, 8'h3C);
    exp_out = '0;
    exp_out[47:40] = 8'h3C;
    check("wr_out5", out_ports, exp_out);
    rd("rd_out5", 8'h45, 8'h3C);
    wr(8'h4F, 8'h81);
    wr(8'h50, 8'hFF);
    wr(8'h00, 8'h11);
    exp_out[127:120] = 8'h81;
    check("wr_out_last_and_unmapped", out_ports, exp_out);
    rd("rd_out_last", 8'h4F, 8'h81);
    rd("rd_unmapped_50", 8'h50, 8'h00);
    rd("rd_in0_after_ro_write", 8'h00, 8'hA5);

    // mask register width
    wr(8'hF1, 8'hFF);
    rd("rd_mask_upper_zero", 8'hF1, 8'h0F);
    wr(8'hF1, 8'h01);
    rd("rd_mask", 8'hF1, 8'h01);

    // single interrupt, ack, EOI
    irq_req = 4'h1;
    tick();
    irq_req = 4'h0;
    wait_sync();
    check("irq0_pending", 128'(irq_pending), 128'h1);
    check("irq0_int_not_yet", 128'(interrupt), 128'h0);
    tick();
    check("irq0_int", 128'(interrupt), 128'h1);
    rd("rd_cause0", 8'hF2, 8'h01);
    ack();
    check("irq0_ack_clears", 128'(interrupt), 128'h0);
    tick(); tick(); tick();
    check("irq0_stays_low_unarmed", 128'(interrupt), 128'h0);
    wr(8'hF0, 8'h01);
    check("irq0_w1c", 128'(irq_pending), 128'h0);
    tick();
    check("irq0_no_reassert", 128'(interrupt), 128'h0);

    // request while disarmed, released by EOI of zero
    wr(8'hF1, 8'h03);
    ack();
    irq_req = 4'h2;
    tick();
    irq_req = 4'h0;
    wait_sync();
    tick(); tick();
    check("irq1_pending", 128'(irq_pending), 128'h2);
    check("irq1_held_off", 128'(interrupt), 128'h0);
    rd("rd_cause1", 8'hF2, 8'h02);
    wr(8'hF0, 8'h00);
    check("irq1_eoi_edge", 128'(interrupt), 128'h0);
    tick();
    check("irq1_after_eoi", 128'(interrupt), 128'h1);
    rd("rd_pend1", 8'hF0, 8'h02);
    ack();
    check("irq1_ack", 128'(interrupt), 128'h0);

    // edge on bit 2 coinciding with W1C of bit 2: set wins
    irq_req = 4'h4;
    wait_sync();
    wr(8'hF0, 8'h04);
    check("set_beats_w1c", 128'(irq_pending), 128'h6);
    wr(8'hF0, 8'h06);
    check("w1c_two_bits", 128'(irq_pending), 128'h0);
    irq_req = 4'h0;

    // asynchronous reset while interrupt is asserted
    wr(8'hF0, 8'h00);
    irq_req = 4'h1;
    tick();
    irq_req = 4'h0;
    wait_sync();
    tick();
    check("pre_reset_int", 128'(interrupt), 128'h1);
    irq_req = 4'h8;
    #2 sysreset = 1'b0;
    #1;
    check("async_rst_int", 128'(interrupt), 128'h0);
    check("async_rst_out_ports", out_ports, 128'h0);
    check("async_rst_data_out", 128'(io_data_out), 128'h0);
    check("async_rst_pending", 128'(irq_pending), 128'h0);
    @(posedge sysclk);
    #1 sysreset = 1'b1;
    port_id = 8'h00;
    tick();
    wait_sync();
    check("held_req_one_edge", 128'(irq_pending), 128'h8);
    tick(); tick();
    check("post_rst_int_masked", 128'(interrupt), 128'h0);
    rd("post_rst_mask", 8'hF1, 8'h00);
    rd("post_rst_pend", 8'hF0, 8'h08);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
